// File: rtl/minirisc_prog_seq.sv
`default_nettype none
// ============================================================================
// Module      : minirisc_prog_seq
// Description : Program buffer and instruction sequencer for tt_um_minirisc.
//               Captures (opcode, operand) byte pairs while idle and replays
//               them to the core over a valid/ready issue handshake, with
//               free-run, single-step, halt and 0x00 end-of-program support.
//               Optional build macro MINIRISC_SEQ_LOOP_EN makes the program
//               wrap from its final entry back to entry 0 instead of ending.
// Revision    : 1.0 - initial release
// ============================================================================
module minirisc_prog_seq #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int W     = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic          load_en,
    input  logic [W-1:0]  load_op,
    input  logic [W-1:0]  load_arg,
    input  logic          start,
    input  logic          step_mode,
    input  logic          step,
    input  logic          halt_req,
    output logic          issue_valid,
    output logic [W-1:0]  issue_op,
    output logic [W-1:0]  issue_arg,
    input  logic          issue_ready,
    output logic [AW-1:0] pc,
    output logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [1:0]    S_IDLE    = 2'd0;
    localparam logic [1:0]    S_RUN     = 2'd1;
    localparam logic [1:0]    S_PAUSE   = 2'd2;
    localparam logic [1:0]    S_DONE    = 2'd3;

    localparam logic [AW:0]   c_depth   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_len_one = (AW+1)'(1);
    localparam logic [AW-1:0] c_pc_one  = AW'(1);
    localparam logic [W-1:0]  c_end_op  = '0;

    logic [1:0]     r_state;
    logic [2*W-1:0] r_mem [DEPTH];
    logic [AW-1:0]  r_pc;
    logic [AW:0]    r_len;
    logic           r_valid;
    logic [W-1:0]   r_op;
    logic [W-1:0]   r_arg;
    logic           r_busy;
    logic           r_done;
    logic           r_err;

    logic           w_accept;
    logic           w_end_op;
    logic           w_last;
    logic           w_finish;
    logic [AW-1:0]  w_pc_adv;
    logic           w_store_ok;

    assign w_accept   = r_valid & issue_ready;
    assign w_end_op   = (r_op == c_end_op);
    assign w_last     = w_end_op | ({1'b0, r_pc} == (r_len - c_len_one));
    // Wrapping only happens in loop builds; otherwise the final entry finishes.
    assign w_pc_adv   = w_last ? '0 : (r_pc + c_pc_one);
    assign w_store_ok = (r_state == S_IDLE) & load_en & (r_len < c_depth);

`ifdef MINIRISC_SEQ_LOOP_EN
    assign w_finish   = w_end_op;
`else
    assign w_finish   = w_last;
`endif

    // Program store: written only while idle and not full; no reset needed.
    always_ff @(posedge clk) begin
        if (!rst && ena && w_store_ok) begin
            r_mem[r_len[AW-1:0]] <= {load_op, load_arg};
        end
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_len   <= '0;
            r_valid <= 1'b0;
            r_op    <= '0;
            r_arg   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else if (ena) begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (load_en) begin
                        // A simultaneous start is deliberately dropped here.
                        if (r_len < c_depth) begin
                            r_len <= r_len + c_len_one;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end else if (start) begin
                        if (r_len == '0) begin
                            r_err <= 1'b1;
                        end else begin
                            r_pc           <= '0;
                            r_state        <= S_RUN;
                            r_busy         <= 1'b1;
                            r_valid        <= 1'b1;
                            {r_op, r_arg}  <= r_mem[0];
                        end
                    end
                end
                S_RUN: begin
                    if (halt_req) begin
                        // An accept in this cycle still counts as issued.
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                        r_pc    <= '0;
                        r_busy  <= 1'b0;
                    end else if (w_accept) begin
                        if (w_finish) begin
                            r_state <= S_DONE;
                            r_valid <= 1'b0;
                            r_pc    <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_pc <= w_pc_adv;
                            if (step_mode) begin
                                r_state <= S_PAUSE;
                                r_valid <= 1'b0;
                            end else begin
                                {r_op, r_arg} <= r_mem[w_pc_adv];
                            end
                        end
                    end
                end
                S_PAUSE: begin
                    if (halt_req) begin
                        r_state <= S_IDLE;
                        r_pc    <= '0;
                        r_busy  <= 1'b0;
                    end else if (step || !step_mode) begin
                        r_state       <= S_RUN;
                        r_valid       <= 1'b1;
                        {r_op, r_arg} <= r_mem[r_pc];
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign issue_valid = r_valid;
    assign issue_op    = r_op;
    assign issue_arg   = r_arg;
    assign pc          = r_pc;
    assign len         = r_len;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;

endmodule
`default_nettype wire

// File: doc/minirisc_prog_seq.md
Name: minirisc_prog_seq

Overview:
Program buffer and instruction sequencer in front of the tt_um_minirisc core.
- Captures (opcode, operand) byte pairs presented on the ui_in/uio_in pads into a small program store.
- On start, replays the stored pairs to the core through a valid/ready issue handshake.
- Supports free-run, single-step, halt, and an end-of-program marker (opcode 0x00).

Parameters:
DEPTH, 8, number of program entries (power of two, 2..16)
AW, 3, address width, equal to log2(DEPTH)
W, 8, opcode and operand width

Ports:
clk  in  1  core clock; the only clock
rst  in  1  synchronous, active-high reset
ena  in  1  clock enable; when low, all state and outputs hold
load_en  in  1  write the load_op/load_arg pair into the next free entry
load_op  in  W  opcode byte (from ui_in)
load_arg  in  W  operand byte (from uio_in)
start  in  1  begin issuing from entry 0
step_mode  in  1  1 = pause after every issued instruction
step  in  1  release one pause (single-cycle pulse)
halt_req  in  1  abort the run and return to IDLE
issue_valid  out  1  issue_op/issue_arg hold a valid instruction
issue_op  out  W  opcode to the core
issue_arg  out  W  operand to the core
issue_ready  in  1  core accepts the instruction this cycle
pc  out  AW  index of the current or next entry
len  out  AW+1  number of loaded entries (0..DEPTH)
busy  out  1  state is RUN or PAUSE
done  out  1  one-cycle pulse when the program completes
err  out  1  sticky error flag; cleared only by rst

Behaviour:
- All registers update only on the rising edge of clk with ena=1. Reset has priority over ena.
- Reset values:
  - state=IDLE, pc=0, len=0.
  - issue_valid=0, issue_op=0, issue_arg=0.
  - busy=0, done=0, err=0.
  - Memory contents are don't-care.
- States: IDLE, RUN, PAUSE, DONE.

IDLE:
- load_en with len<DEPTH: mem[len] <= {load_op, load_arg}, len <= len+1.
- load_en with len==DEPTH: write is dropped and err <= 1.
- start with len>0: pc <= 0, go to RUN. issue_valid rises on the next cycle.
- start with len==0: err <= 1, stay in IDLE.
- start together with load_en: the load is performed and start is ignored.
- load_en in any state other than IDLE is ignored and does not set err.

RUN:
- issue_valid=1; issue_op/issue_arg = mem[pc], registered outputs.
- Once issue_valid is asserted, the payload stays stable until accepted.
- On accept (issue_valid && issue_ready):
  - If issue_op==0x00 or pc==len-1: go to DONE.
  - Else if step_mode=1: pc <= pc+1, go to PAUSE.
  - Else: pc <= pc+1, remain in RUN. Back-to-back issue gives 1 instruction per cycle.
- Opcode 0x00 is the end marker and is itself issued to the core.

PAUSE:
- issue_valid=0.
- step returns to RUN; the next instruction is valid the following cycle.
- Clearing step_mode while in PAUSE also returns to RUN.

DONE:
- done=1 for exactly one cycle, issue_valid=0, then go to IDLE.
- pc resets to 0; len is kept so the program can be re-run with start.

halt_req:
- In RUN or PAUSE, goes to IDLE on the next edge, issue_valid <= 0, pc <= 0. done is not pulsed.
- If an accept occurs in the same cycle, that instruction counts as issued; halt still wins over the transition to DONE or PAUSE.
- In IDLE or DONE, halt_req has no effect.

Other rules:
- start while busy is ignored.
- busy = state is RUN or PAUSE.

Optional Feature:
MINIRISC_SEQ_LOOP_EN
- Defined: when the final entry is accepted (pc==len-1, opcode not 0x00), pc wraps to 0 and the block stays in RUN (or PAUSE in step_mode). done is not pulsed. Only an opcode 0x00 entry or halt_req ends the run.
- Undefined: the final entry ends the run as described in Behaviour.

Test Plan:
- Reset/idle: assert rst 2 cycles -> all outputs 0, len=0; start with len==0 -> err=1, busy=0.
- Load and free-run: load (01,01),(02,02),(03,03) with issue_ready=1, then start -> issue pairs 01/01, 02/02, 03/03 on 3 consecutive cycles; done pulses once; len=3, pc=0.
- Backpressure: issue_ready low 4 cycles during entry 1 -> issue_op=02, issue_arg=02 held stable; pc stays at 1 until accept.
- End marker and overflow: load 01..07 then 00 (8 entries), then a 9th load -> err=1, len=8. Run -> 8 issues, with 00 last, then done.
- Step and halt: step_mode=1, 3-entry program -> PAUSE after each accept, one issue per step pulse. halt_req in PAUSE at pc=1 -> IDLE, no done pulse, pc=0.
- MINIRISC_SEQ_LOOP_EN: 2 entries (05,AA),(06,BB) -> issue sequence 05,06,05,06... until halt_req; done never pulses.
